// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator
//   Front end of the vending transaction controller. Synchronises the raw coin
//   sensor, turns each rising edge of the synchronised level into one accept
//   event, keeps a ceiling-limited credit total, compares it against a loadable
//   price and, on vend commit, turns the credit into a change amount that is
//   held until the change stage acknowledges payment.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_COLLECT | taking coins, price loads and vend commits
//   ST_PAYOUT  | change_amt_o owed and held; every coin rejected until ack
module coin_credit_accumulator #(
    parameter int CREDIT_W      = 10,
    parameter int MAX_CREDIT    = 500,
    parameter int PRICE_DEFAULT = 75,
    parameter int VAL0          = 5,
    parameter int VAL1          = 10,
    parameter int VAL2          = 25,
    parameter int VAL3          = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_in_i,
    input  logic [1:0]          coin_type_i,
    input  logic                price_load_i,
    input  logic [CREDIT_W-1:0] price_in_i,
    input  logic                vend_commit_i,
    input  logic                change_ack_i,
    output logic                coin_o,
    output logic                coin_reject_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                sufficient_o,
    output logic [CREDIT_W-1:0] change_amt_o,
    output logic                busy_o
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_PAYOUT  = 1'b1;

    // One spare bit on the add so an over-ceiling coin can never wrap.
    localparam int                SUM_W   = CREDIT_W + 1;
    localparam logic [CREDIT_W:0] MAX_SUM = SUM_W'(MAX_CREDIT);

    logic                coin_s1_q, coin_s2_q, coin_s2_dly_q;
    logic [1:0]          type_s1_q, type_s2_q;

    logic [0:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                sufficient_q, sufficient_d;
    logic                coin_q, coin_d;
    logic                reject_q, reject_d;

    logic                accept_ev;
    logic [CREDIT_W:0]   coin_value;
    logic [CREDIT_W:0]   credit_sum;
    logic                covers_price;
    logic                commit;

    // Two-flop synchronisers for the sensor level and its type, plus the edge register.
    always_ff @(posedge clk) begin
        if (rst) begin
            coin_s1_q     <= 1'b0;
            coin_s2_q     <= 1'b0;
            coin_s2_dly_q <= 1'b0;
            type_s1_q     <= 2'd0;
            type_s2_q     <= 2'd0;
        end else begin
            coin_s1_q     <= coin_in_i;
            coin_s2_q     <= coin_s1_q;
            coin_s2_dly_q <= coin_s2_q;
            type_s1_q     <= coin_type_i;
            type_s2_q     <= type_s1_q;
        end
    end

    assign accept_ev = coin_s2_q & ~coin_s2_dly_q;

    // Denomination decode from the type synchronised alongside the level.
    always_comb begin
        coin_value = SUM_W'(VAL0);
        case (type_s2_q)
            2'd0: coin_value = SUM_W'(VAL0);
            2'd1: coin_value = SUM_W'(VAL1);
            2'd2: coin_value = SUM_W'(VAL2);
            2'd3: coin_value = SUM_W'(VAL3);
            default: coin_value = SUM_W'(VAL0);
        endcase
    end

    assign credit_sum   = {1'b0, credit_q} + coin_value;
    assign covers_price = (credit_q >= price_q);
    // Commit keys off the registered flag so it matches what the FSM downstream saw.
    assign commit       = (state_q == ST_COLLECT) & vend_commit_i & sufficient_q;

    // Next-state logic: commit outranks both the coin and a price load in the same cycle.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        price_d      = price_q;
        change_d     = change_q;
        coin_d       = 1'b0;
        reject_d     = 1'b0;
        sufficient_d = covers_price;
        case (state_q)
            ST_COLLECT: begin
                if (commit) begin
                    // The clamp only matters if the price rose in the cycle the flag was stale.
                    change_d = covers_price ? (credit_q - price_q) : '0;
                    credit_d = '0;
                    reject_d = accept_ev;
                    state_d  = ST_PAYOUT;
                end else begin
                    if (accept_ev) begin
                        if (credit_sum <= MAX_SUM) begin
                            credit_d = credit_sum[CREDIT_W-1:0];
                            coin_d   = 1'b1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                    if (price_load_i) begin
                        price_d = price_in_i;
                    end
                end
            end
            ST_PAYOUT: begin
                reject_d = accept_ev;
                if (change_ack_i) begin
                    change_d = '0;
                    state_d  = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // Controller registers; reset also discards any change still owed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_COLLECT;
            credit_q     <= '0;
            price_q      <= CREDIT_W'(PRICE_DEFAULT);
            change_q     <= '0;
            sufficient_q <= 1'b0;
            coin_q       <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            price_q      <= price_d;
            change_q     <= change_d;
            sufficient_q <= sufficient_d;
            coin_q       <= coin_d;
            reject_q     <= reject_d;
        end
    end

    assign coin_o        = coin_q;
    assign coin_reject_o = reject_q;
    assign credit_o      = credit_q;
    assign sufficient_o  = sufficient_q;
    assign change_amt_o  = change_q;
    assign busy_o        = (state_q == ST_PAYOUT);

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Bench for coin_credit_accumulator: directed scenarios followed by random
// traffic, checked cycle by cycle against a behavioural model through a queue.
module tb_coin_credit_accumulator;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_in = 1'b0;
    logic [1:0]    coin_type = 2'd0;
    logic          price_load = 1'b0;
    logic [CW-1:0] price_in = '0;
    logic          vend_commit = 1'b0;
    logic          change_ack = 1'b0;
    logic          coin_o, coin_reject_o, sufficient_o, busy_o;
    logic [CW-1:0] credit_o, change_amt_o;

    always #5 clk = ~clk;

    coin_credit_accumulator dut (
        .clk           (clk),
        .rst           (rst),
        .coin_in_i     (coin_in),
        .coin_type_i   (coin_type),
        .price_load_i  (price_load),
        .price_in_i    (price_in),
        .vend_commit_i (vend_commit),
        .change_ack_i  (change_ack),
        .coin_o        (coin_o),
        .coin_reject_o (coin_reject_o),
        .credit_o      (credit_o),
        .sufficient_o  (sufficient_o),
        .change_amt_o  (change_amt_o),
        .busy_o        (busy_o)
    );

    typedef struct packed {
        logic          coin;
        logic          rej;
        logic [CW-1:0] credit;
        logic          suff;
        logic [CW-1:0] change;
        logic          busy;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // Reference model: credit/price in plain integers, sensor modelled as the
    // history of sampled levels (an event is a level that was high two edges
    // ago and low three edges ago).
    int   vals[4] = '{5, 10, 25, 100};
    int   m_credit = 0, m_price = 75, m_change = 0;
    bit   m_suff = 0, m_busy = 0, m_coin = 0, m_rej = 0;
    bit   h_in[3] = '{0, 0, 0};
    int   h_ty[3] = '{0, 0, 0};

    task automatic tick();
        obs_t e;
        bit   ev, suff_old, suff_new;
        int   v;
        if (rst) begin
            m_credit = 0; m_price = 75; m_change = 0;
            m_suff = 0; m_busy = 0; m_coin = 0; m_rej = 0;
            h_in = '{0, 0, 0};
            h_ty = '{0, 0, 0};
        end else begin
            ev       = h_in[1] && !h_in[2];
            v        = vals[h_ty[1]];
            suff_old = m_suff;
            suff_new = (m_credit >= m_price);
            m_coin   = 0;
            m_rej    = 0;
            if (!m_busy) begin
                if (vend_commit && suff_old) begin
                    m_change = (m_credit >= m_price) ? m_credit - m_price : 0;
                    m_credit = 0;
                    m_busy   = 1;
                    m_rej    = ev;
                end else begin
                    if (ev) begin
                        if (m_credit + v <= 500) begin
                            m_credit = m_credit + v;
                            m_coin   = 1;
                        end else begin
                            m_rej = 1;
                        end
                    end
                    if (price_load) m_price = int'(price_in);
                end
            end else begin
                m_rej = ev;
                if (change_ack) begin
                    m_change = 0;
                    m_busy   = 0;
                end
            end
            m_suff  = suff_new;
            h_in[2] = h_in[1]; h_in[1] = h_in[0]; h_in[0] = coin_in;
            h_ty[2] = h_ty[1]; h_ty[1] = h_ty[0]; h_ty[0] = int'(coin_type);
        end
        e.coin   = m_coin;
        e.rej    = m_rej;
        e.credit = CW'(m_credit);
        e.suff   = m_suff;
        e.change = CW'(m_change);
        e.busy   = m_busy;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: one expected snapshot per clock edge, compared 1 time unit later.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.coin   = coin_o;
                a.rej    = coin_reject_o;
                a.credit = credit_o;
                a.suff   = sufficient_o;
                a.change = change_amt_o;
                a.busy   = busy_o;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got coin=%0b rej=%0b credit=%0d suff=%0b change=%0d busy=%0b, expected coin=%0b rej=%0b credit=%0d suff=%0b change=%0d busy=%0b",
                             cycle, a.coin, a.rej, a.credit, a.suff, a.change, a.busy,
                             e.coin, e.rej, e.credit, e.suff, e.change, e.busy);
                end
                checks++;
                if (coin_o === 1'b1 && coin_reject_o === 1'b1) begin
                    errors++;
                    $display("FAIL exclusive cycle %0d: got coin=1 reject=1, expected at most one", cycle);
                end
                cycle++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of stimulus by time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic insert(input int t, input int hold);
        coin_type = 2'(t);
        coin_in   = 1'b1;
        repeat (hold) tick();
        coin_in   = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int run;
        // 1: held level gives one coin of 25
        do_reset();
        insert(2, 4);
        idle(2);
        // 2: ceiling at 500, next coin refused
        do_reset();
        repeat (5) insert(3, 2);
        insert(0, 2);
        idle(2);
        // 3: 100 against price 75, commit, then ack
        do_reset();
        insert(3, 2);
        idle(2);
        vend_commit = 1'b1; tick(); vend_commit = 1'b0;
        idle(2);
        change_ack = 1'b1; tick(); change_ack = 1'b0;
        idle(2);
        // 4: insufficient commit ignored, then price drop to 50
        do_reset();
        insert(2, 2);
        insert(2, 2);
        idle(1);
        vend_commit = 1'b1; tick(); vend_commit = 1'b0;
        idle(1);
        price_in = 10'd50; price_load = 1'b1; tick(); price_load = 1'b0;
        idle(3);
        // 5: coin event coincident with commit, then a coin during payout
        do_reset();
        insert(3, 2);
        idle(2);
        coin_type = 2'd1; coin_in = 1'b1;
        tick();
        tick();
        vend_commit = 1'b1; tick(); vend_commit = 1'b0;
        coin_in = 1'b0;
        idle(3);
        insert(1, 2);
        // 6: reset during payout
        do_reset();
        idle(2);
        // price 0 corner
        price_in = '0; price_load = 1'b1; tick(); price_load = 1'b0;
        idle(2);

        // random traffic
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (run == 0) begin
                coin_in = ~coin_in;
                run = $urandom_range(1, 6);
                if (coin_in) coin_type = 2'($urandom_range(0, 3));
            end
            run--;
            price_load  = ($urandom_range(0, 19) == 0);
            price_in    = ($urandom_range(0, 4) == 0) ? '0 : CW'($urandom_range(0, 300));
            vend_commit = ($urandom_range(0, 9) == 0);
            change_ack  = ($urandom_range(0, 5) == 0);
            tick();
        end
        rst = 1'b0; coin_in = 1'b0; price_load = 1'b0; vend_commit = 1'b0; change_ack = 1'b0;
        idle(4);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending snapshots, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
